// File: rtl/linreg_pkg.sv
// Shared widths, FSM state type and sample/accumulator types for the linear-regression sum accumulator.
// Latency: none, definitions only.
// Backpressure: none, definitions only.
package linreg_pkg;

  localparam int DATA_W = 20;
  localparam int ADDR_W = 8;
  localparam int ACC_W  = 48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  // Sign-extend one sample to accumulator width.
  function automatic acc_t sext(input sample_t s);
    return {{(ACC_W-DATA_W){s[DATA_W-1]}}, s};
  endfunction

endpackage

// File: rtl/linreg_sum_accumulator_if.sv
// Bundle of the accumulator's start/memory/result signals; master = controller + memory side, slave = accumulator.
// Latency: none, wiring only.
// Backpressure: none; LINREG_VAR_LEN_EN adds the n_len sweep-length input.
interface linreg_sum_accumulator_if;
  import linreg_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] rd_addr;
  sample_t           x_in;
  sample_t           y_in;
  logic              busy;
  logic              done;
  acc_t              sum_x;
  acc_t              sum_y;
  acc_t              sum_xy;
  acc_t              sum_xx;
`ifdef LINREG_VAR_LEN_EN
  logic [ADDR_W:0]   n_len;
`endif

  modport master (
`ifdef LINREG_VAR_LEN_EN
    output n_len,
`endif
    output start, x_in, y_in,
    input  rd_addr, busy, done, sum_x, sum_y, sum_xy, sum_xx
  );

  modport slave (
`ifdef LINREG_VAR_LEN_EN
    input  n_len,
`endif
    input  start, x_in, y_in,
    output rd_addr, busy, done, sum_x, sum_y, sum_xy, sum_xx
  );

endinterface

// File: rtl/linreg_mac.sv
// Signed multiply-accumulate lane: acc += a*b (full-width product, sign-extended), wrapping modulo 2^ACC_W.
// Latency: one cycle from operands to updated accumulator.
// Backpressure: none; clr_i has priority over en_i, and the value holds when neither is set.
module linreg_mac
  import linreg_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    clr_i,
  input  logic    en_i,
  input  sample_t a_i,
  input  sample_t b_i,
  output acc_t    acc_o
);

  localparam int PROD_W = 2 * DATA_W;

  logic signed [PROD_W-1:0] prod;
  acc_t                     acc_d;
  acc_t                     acc_q;

  assign prod = PROD_W'(a_i) * PROD_W'(b_i);

  // Next accumulator value: clear, add the sign-extended product, or hold.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/linreg_sum_accumulator.sv
// Sweeps addresses 0..len-1 into the x/y sample memories and accumulates sum_x, sum_y, sum_xy and sum_xx.
// Latency: done pulses len+2 cycles after an accepted start (memory read latency is one cycle).
// Backpressure: start is only accepted in IDLE; LINREG_VAR_LEN_EN makes len a latched, clamped n_len instead of N.
module linreg_sum_accumulator
  import linreg_pkg::*;
#(
  parameter int N = 150
)
(
  input  logic                     clk,
  input  logic                     reset,
  linreg_sum_accumulator_if.slave  bus
);

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              vld_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] last_addr;
  logic              start_acc;
  acc_t              sum_x_q, sum_x_d;
  acc_t              sum_y_q, sum_y_d;
  acc_t              sum_xy;
  acc_t              sum_xx;

  assign start_acc = bus.start && (state_q == IDLE);

`ifdef LINREG_VAR_LEN_EN
  localparam logic [ADDR_W:0] N_LEN = (ADDR_W+1)'(N);

  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] len_clamped;

  assign len_clamped = (bus.n_len > N_LEN) ? N_LEN : bus.n_len;
  // A full 2^ADDR_W length wraps the low bits to 0, so the minus one still lands on the top address.
  assign last_addr   = len_q[ADDR_W-1:0] - 1'b1;
`else
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

  assign last_addr = LAST_ADDR;
`endif

  // Sweep FSM: address counter, read-valid pipe flag and registered busy/done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef LINREG_VAR_LEN_EN
      len_q   <= '0;
`endif
    end else begin
      // Data for the address issued this cycle returns next cycle.
      vld_q  <= (state_q == ISSUE);
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            cnt_q <= '0;
`ifdef LINREG_VAR_LEN_EN
            len_q <= len_clamped;
            if (len_clamped == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ISSUE;
              busy_q  <= 1'b1;
            end
`else
            state_q <= ISSUE;
            busy_q  <= 1'b1;
`endif
          end
        end
        ISSUE: begin
          if (cnt_q == last_addr) begin
            state_q <= DRAIN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DRAIN: begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Plain sums: clear on an accepted start, add while returned data is valid, otherwise hold.
  always_comb begin
    sum_x_d = sum_x_q;
    sum_y_d = sum_y_q;
    if (start_acc) begin
      sum_x_d = '0;
      sum_y_d = '0;
    end else if (vld_q) begin
      sum_x_d = sum_x_q + sext(bus.x_in);
      sum_y_d = sum_y_q + sext(bus.y_in);
    end
  end

  // Plain sum registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_x_q <= '0;
      sum_y_q <= '0;
    end else begin
      sum_x_q <= sum_x_d;
      sum_y_q <= sum_y_d;
    end
  end

  linreg_mac u_mac_xy (
    .clk   (clk),
    .reset (reset),
    .clr_i (start_acc),
    .en_i  (vld_q),
    .a_i   (bus.x_in),
    .b_i   (bus.y_in),
    .acc_o (sum_xy)
  );

  linreg_mac u_mac_xx (
    .clk   (clk),
    .reset (reset),
    .clr_i (start_acc),
    .en_i  (vld_q),
    .a_i   (bus.x_in),
    .b_i   (bus.x_in),
    .acc_o (sum_xx)
  );

  assign bus.rd_addr = cnt_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.sum_x   = sum_x_q;
  assign bus.sum_y   = sum_y_q;
  assign bus.sum_xy  = sum_xy;
  assign bus.sum_xx  = sum_xx;

endmodule

// File: tb/tb_linreg_sum_accumulator.sv
// Bench for linreg_sum_accumulator: sample memories, timeline/sum model, per-cycle compare, directed sweeps.
// Latency: expects done len+2 cycles after an accepted start.
// Backpressure: starts while busy or in the done cycle must be ignored; LINREG_VAR_LEN_EN enables n_len cases.
module tb_linreg_sum_accumulator;
  import linreg_pkg::*;

  localparam int N = 150;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  linreg_sum_accumulator_if bus ();

  linreg_sum_accumulator #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Sample memories with one-cycle synchronous read.
  sample_t xmem [256];
  sample_t ymem [256];

  always @(posedge clk) begin
    bus.x_in <= xmem[bus.rd_addr];
    bus.y_in <= ymem[bus.rd_addr];
  end

  int checks = 0;
  int errors = 0;

  // Model: a sweep accepted in cycle m_s with length m_L; sums are closed-form over the memory.
  int   cyc = 0;
  bit   m_active = 1'b0;
  int   m_s = 0;
  int   m_L = 0;
  acc_t e_x, e_y, e_xy, e_xx;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic compute_expected(input int len);
    longint sx = 0, sy = 0, sxy = 0, sxx = 0;
    for (int i = 0; i < len; i++) begin
      sx  += longint'(xmem[i]);
      sy  += longint'(ymem[i]);
      sxy += longint'(xmem[i]) * longint'(ymem[i]);
      sxx += longint'(xmem[i]) * longint'(xmem[i]);
    end
    e_x  = acc_t'(sx);
    e_y  = acc_t'(sy);
    e_xy = acc_t'(sxy);
    e_xx = acc_t'(sxx);
  endtask

  function automatic int done_rel(input int len);
    return (len == 0) ? 1 : len + 2;
  endfunction

  // Per-cycle compare, 1 time unit after each rising edge.
  int   c_rel;
  int   c_drel;
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!m_active) begin
        chk("idle_busy",   longint'(bus.busy),    0);
        chk("idle_done",   longint'(bus.done),    0);
        chk("idle_rdaddr", longint'(bus.rd_addr), 0);
        chk("idle_sum_x",  bus.sum_x,  0);
        chk("idle_sum_y",  bus.sum_y,  0);
        chk("idle_sum_xy", bus.sum_xy, 0);
        chk("idle_sum_xx", bus.sum_xx, 0);
      end else begin
        c_rel  = cyc - m_s;
        c_drel = done_rel(m_L);
        chk("busy", longint'(bus.busy), (m_L > 0 && c_rel >= 1 && c_rel <= m_L + 1) ? 1 : 0);
        chk("done", longint'(bus.done), (c_rel == c_drel) ? 1 : 0);
        chk("rd_addr", longint'(bus.rd_addr),
            (m_L == 0) ? 0 : ((c_rel <= m_L) ? c_rel - 1 : m_L - 1));
        if (c_rel >= c_drel) begin
          chk("sum_x",  bus.sum_x,  e_x);
          chk("sum_y",  bus.sum_y,  e_y);
          chk("sum_xy", bus.sum_xy, e_xy);
          chk("sum_xx", bus.sum_xx, e_xx);
        end
      end
    end
  end

  // Called at a falling edge; holds start for one cycle and returns at the next falling edge.
  task automatic drive_start(input int ln);
    int eff;
    bus.start = 1'b1;
`ifdef LINREG_VAR_LEN_EN
    bus.n_len = (ADDR_W+1)'(ln);
`endif
    eff = (ln > N) ? N : ln;
    if (!m_active || (cyc - m_s) > done_rel(m_L)) begin
      m_s = cyc;
      m_L = eff;
      compute_expected(eff);
      m_active = 1'b1;
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_active = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_rel(input int r);
    while (cyc - m_s < r) @(negedge clk);
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    int n = 0;
    while (bus.done !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL %s: done not seen within 1000 cycles, expected after %0d", name, exp_lat);
    end else if (cyc - m_s != exp_lat) begin
      errors++;
      $display("FAIL %s: done latency %0d, expected %0d", name, cyc - m_s, exp_lat);
    end
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 256; i++) begin
      xmem[i] = sample_t'(i);
      ymem[i] = sample_t'(2 * i + 3);
    end
  endtask

  task automatic load_signed();
    for (int i = 0; i < 256; i++) begin
      xmem[i] = sample_t'(-524288);
      ymem[i] = sample_t'(-1);
    end
  endtask

  task automatic load_b();
    for (int i = 0; i < 256; i++) begin
      xmem[i] = sample_t'(3);
      ymem[i] = sample_t'(-i);
    end
  endtask

  task automatic pin_ramp(input string tag);
    chk({tag, "_model_sum_xy"}, e_xy, 2261075);
    chk({tag, "_sum_x"},  bus.sum_x,  11175);
    chk({tag, "_sum_y"},  bus.sum_y,  22800);
    chk({tag, "_sum_xy"}, bus.sum_xy, 2261075);
    chk({tag, "_sum_xx"}, bus.sum_xx, 1113775);
  endtask

  int dn;

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
`ifdef LINREG_VAR_LEN_EN
    bus.n_len = '0;
`endif
    for (int i = 0; i < 256; i++) begin
      xmem[i] = '0;
      ymem[i] = '0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Ramp memory, single start.
    load_ramp();
    drive_start(N);
    wait_done("ramp_latency", 152);
    pin_ramp("ramp");
    repeat (5) @(negedge clk);

    // Most-negative x, y = -1.
    load_signed();
    drive_start(N);
    wait_done("signed_latency", 152);
    chk("signed_model_sum_xx", e_xx, 64'sd41231686041600);
    chk("signed_sum_x",  bus.sum_x,  -78643200);
    chk("signed_sum_y",  bus.sum_y,  -150);
    chk("signed_sum_xy", bus.sum_xy, 78643200);
    chk("signed_sum_xx", bus.sum_xx, 64'sd41231686041600);
    repeat (5) @(negedge clk);

    // Extra starts at cycle 10 (busy) and 151 (last accumulate) are ignored.
    load_ramp();
    drive_start(N);
    wait_rel(10);
    drive_start(N);
    wait_rel(151);
    drive_start(N);
    wait_done("restart_latency", 152);
    pin_ramp("restart");
    repeat (5) @(negedge clk);

    // Reset at cycle 60 of a sweep: no done, then a clean full sweep.
    drive_start(N);
    wait_rel(60);
    do_reset();
    chk("rst_busy",   longint'(bus.busy),    0);
    chk("rst_rdaddr", longint'(bus.rd_addr), 0);
    chk("rst_sum_xy", bus.sum_xy, 0);
    dn = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus.done === 1'b1) dn++;
    end
    chk("rst_no_done", dn, 0);
    drive_start(N);
    wait_done("after_rst_latency", 152);
    pin_ramp("after_rst");

    // Back-to-back: start the cycle after done with new memory contents.
    @(negedge clk);
    load_b();
    drive_start(N);
    wait_done("b2b_latency", 152);
    chk("b2b_sum_x",  bus.sum_x,  450);
    chk("b2b_sum_y",  bus.sum_y,  -11175);
    chk("b2b_sum_xy", bus.sum_xy, -33525);
    chk("b2b_sum_xx", bus.sum_xx, 1350);
    repeat (5) @(negedge clk);

`ifdef LINREG_VAR_LEN_EN
    // Variable sweep length.
    for (int i = 0; i < 256; i++) begin
      xmem[i] = sample_t'(i);
      ymem[i] = sample_t'(i);
    end
    drive_start(4);
    wait_done("vl4_latency", 6);
    chk("vl4_model_sum_xy", e_xy, 14);
    chk("vl4_sum_xy", bus.sum_xy, 14);
    repeat (3) @(negedge clk);
    drive_start(0);
    wait_done("vl0_latency", 1);
    chk("vl0_sum_x",  bus.sum_x,  0);
    chk("vl0_sum_xx", bus.sum_xx, 0);
    repeat (3) @(negedge clk);
    drive_start(200);
    wait_done("vl200_latency", 152);
    chk("vl200_sum_xy", bus.sum_xy, 1113775);
    chk("vl200_sum_x",  bus.sum_x,  11175);
    repeat (3) @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
